// File: rtl/at_seq_accum_pkg.sv
// -----------------------------------------------------------------------------
// at_seq_accum_pkg
// Shared definitions for the multi-beat sequencer / accumulator and its
// saturating adder tree.
//   - FSM state encoding (ST_IDLE, ST_RUN, ST_OUT)
//   - sat_add(): unsigned saturating add, reused by the tree nodes and by the
//     beat accumulator so both saturate identically.
// -----------------------------------------------------------------------------
package at_seq_accum_pkg;

    // Width of the generic operands of sat_add(); callers zero-extend into it
    // and truncate the result back to their own width (which must be < SAT_W).
    localparam int SAT_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_OUT  = 2'd2;

    // Saturating add of two width-bit unsigned values. The sum is formed one
    // bit wider than the operands; any bit at or above position 'width' is the
    // carry out and means the result clamps to 2^width-1.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
        if ((sum >> width) != '0) begin
            return max_val[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/at_seq_accum_tree.sv
// -----------------------------------------------------------------------------
// at_seq_accum_tree
// Combinational saturating adder tree (AT). Sums LENGTH unsigned lanes of
// DATA_WIDTH bits; every tree node saturates at 2^DATA_WIDTH-1.
// Ports:
//   in_data  in  DATA_WIDTH*LENGTH  lane vector, lane 0 in the MSBs
//   sum      out DATA_WIDTH         saturated sum of all lanes
// -----------------------------------------------------------------------------
module at_seq_accum_tree
    import at_seq_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 16
) (
    input  logic [DATA_WIDTH*LENGTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]        sum
);

    // Tree is built over the next power of two; missing leaves are zero.
    localparam int LEVELS = (LENGTH > 1) ? $clog2(LENGTH) : 0;
    localparam int P      = 1 << LEVELS;

    logic [DATA_WIDTH-1:0] lane [0:LENGTH-1];
    logic [DATA_WIDTH-1:0] work [0:P-1];

    generate
        for (genvar gi = 0; gi < LENGTH; gi++) begin : g_lane
            assign lane[gi] = in_data[(LENGTH-1-gi)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Pairwise in-place reduction: at each level node k takes nodes 2k and
    // 2k+1 of the previous level. Ascending k never overwrites an entry that
    // is still to be read in the same level.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            work[k] = '0;
        end
        for (int k = 0; k < LENGTH; k++) begin
            work[k] = lane[k];
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < P / 2; k++) begin
                if (k < (P >> (l + 1))) begin
                    work[k] = DATA_WIDTH'(sat_add(SAT_W'(work[2*k]),
                                                  SAT_W'(work[2*k+1]),
                                                  DATA_WIDTH));
                end
            end
        end
    end

    assign sum = work[0];

endmodule

// File: rtl/at_seq_accum.sv
// -----------------------------------------------------------------------------
// at_seq_accum
// Multi-beat sequencer and saturating accumulator around one AT instance.
// A job of num_beats lane vectors is reduced beat by beat and the beat sums
// are accumulated with saturation; the final sum is offered on valid/ready.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, num_beats    job request (honoured only in IDLE), beat count
//   flush               synchronous abort back to IDLE, drops any result
//   busy                high in RUN and OUT
//   err                 one-cycle pulse for a start with an illegal num_beats
//   in_valid/in_ready   input beat handshake, in_data lane vector
//   out_valid/out_ready result handshake, out_sum saturated job sum
// -----------------------------------------------------------------------------
module at_seq_accum
    import at_seq_accum_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int LENGTH     = 16,
    parameter  int MAX_BEATS  = 64,
    localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_beats,
    input  logic                         flush,
    output logic                         busy,
    output logic                         err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*LENGTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_sum
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      nb_q, nb_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] tree_sum;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  nb_legal;

    at_seq_accum_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH)
    ) u_tree (
        .in_data (in_data),
        .sum     (tree_sum)
    );

    assign acc_sum  = DATA_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(tree_sum), DATA_WIDTH));
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign nb_legal = (num_beats != '0) && (num_beats <= CNT_W'(MAX_BEATS));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        err_d   = 1'b0;
        // flush wins over start and over a beat accepted in the same cycle
        if (flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (nb_legal) begin
                            nb_d    = num_beats;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        if (cnt_inc == nb_q) begin
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    // start in the handshake cycle is deliberately not looked at
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            nb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = acc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_at_seq_accum.sv
// -----------------------------------------------------------------------------
// tb_at_seq_accum
// Directed bench for at_seq_accum (DATA_WIDTH=8, LENGTH=4, MAX_BEATS=8).
// Stimulus pushes the hand-computed job sum into a queue when a job starts; a
// monitor on the falling edge compares out_sum with the queue head on every
// out_valid cycle and pops it on the handshake.
// -----------------------------------------------------------------------------
module tb_at_seq_accum;

    localparam int DW    = 8;
    localparam int LEN   = 4;
    localparam int MAXB  = 8;
    localparam int CW    = $clog2(MAXB + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     num_beats = '0;
    logic              flush = 1'b0;
    logic              busy;
    logic              err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW*LEN-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]     exp_q [$];
    logic [DW*LEN-1:0] tbl [0:7];

    at_seq_accum #(
        .DATA_WIDTH (DW),
        .LENGTH     (LEN),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_beats (num_beats),
        .flush     (flush),
        .busy      (busy),
        .err       (err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_sum", 32'(out_sum), 32'(exp_q[0]));
                if (out_ready) begin
                    $display("result: out_sum=%0d expected=%0d t=%0t", out_sum, exp_q[0], $time);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Back-to-back job with out_ready high: beats come from tbl[0..nb-1].
    task automatic run_job(input int nb, input logic [DW-1:0] exp);
        out_ready = 1'b1;
        start     = 1'b1;
        num_beats = CW'(nb);
        tick();
        start = 1'b0;
        exp_q.push_back(exp);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < nb; i++) begin
            check("in_ready_run", 32'(in_ready), 32'd1);
            check("out_valid_early", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = tbl[i];
            tick();
        end
        in_valid = 1'b0;
        check("out_valid_latency", 32'(out_valid), 32'd1);
        check("in_ready_out", 32'(in_ready), 32'd0);
        tick();
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        // ---------------- reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- 1: three beats of {1,1,1,1} -> 12
        for (int i = 0; i < 3; i++) tbl[i] = {8'd1, 8'd1, 8'd1, 8'd1};
        run_job(3, 8'd12);

        // ---------------- 2a: 200 + 200 saturates in the accumulator
        tbl[0] = {8'd100, 8'd100, 8'd0, 8'd0};
        tbl[1] = {8'd100, 8'd100, 8'd0, 8'd0};
        run_job(2, 8'd255);

        // ---------------- 2b: 200 + 100 saturates in the tree
        tbl[0] = {8'd200, 8'd100, 8'd0, 8'd0};
        run_job(1, 8'd255);

        // ---------------- 3: input gaps and output backpressure; 100 + 10
        out_ready = 1'b0;
        start     = 1'b1;
        num_beats = CW'(2);
        tick();
        start = 1'b0;
        exp_q.push_back(8'd110);
        in_valid = 1'b1;
        in_data  = {8'd10, 8'd20, 8'd30, 8'd40};
        tick();
        check("bp_in_ready_mid", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_data  = {8'd99, 8'd99, 8'd99, 8'd99};
        tick();
        tick();
        check("bp_in_ready_gap", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = {8'd1, 8'd2, 8'd3, 8'd4};
        tick();
        in_valid = 1'b0;
        check("bp_in_ready_after", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
            check("bp_busy_hold", 32'(busy), 32'd1);
            start     = (k == 0);
            num_beats = CW'(2);
            tick();
            start = 1'b0;
            check("bp_err_start_in_out", 32'(err), 32'd0);
        end
        check("bp_out_valid_last", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_out_valid_drop", 32'(out_valid), 32'd0);
        check("bp_busy_idle", 32'(busy), 32'd0);

        // ---------------- 4: illegal num_beats 0 and 9
        start     = 1'b1;
        num_beats = CW'(0);
        tick();
        start = 1'b0;
        check("err_nb0", 32'(err), 32'd1);
        check("err_nb0_busy", 32'(busy), 32'd0);
        check("err_nb0_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("err_nb0_pulse", 32'(err), 32'd0);
        start     = 1'b1;
        num_beats = CW'(9);
        tick();
        start = 1'b0;
        check("err_nb9", 32'(err), 32'd1);
        check("err_nb9_busy", 32'(busy), 32'd0);
        check("err_nb9_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("err_nb9_pulse", 32'(err), 32'd0);

        // ---------------- 5: flush with a valid beat in the same cycle
        start     = 1'b1;
        num_beats = CW'(3);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {8'd5, 8'd5, 8'd5, 8'd5};
        tick();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        tbl[0] = {8'd1, 8'd2, 8'd3, 8'd4};
        run_job(1, 8'd10);

        // ---------------- 6: asynchronous reset mid-RUN
        start     = 1'b1;
        num_beats = CW'(2);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {8'd9, 8'd9, 8'd9, 8'd9};
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        tbl[0] = {8'd7, 8'd0, 8'd0, 8'd0};
        run_job(1, 8'd7);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
